// File: rtl/fifo_mem_pkg.sv
// Shared types and width helpers for the FWFT FIFO memory controller.
package fifo_mem_pkg;

    // Output stage: whether the memory read register holds the head entry.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_VALID = 1'b1
    } out_state_e;

    // Pointer width for a memory of the given depth.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy width able to hold 0..depth (and 0..depth+1 with the output stage).
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping memory pointer; depth is a power of two so wrap is natural overflow.
module fifo_ptr
    import fifo_mem_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    output logic [$clog2(N)-1:0] ptr
);

    localparam int PTR_W = ptr_width(N);

    // Pointer register: clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/fifo_mem_ctrl.sv
// First-word-fall-through FIFO controller around an external registered
// single-write/single-read memory. The memory's read register doubles as the
// output stage, giving N+1 entries of capacity and full pop throughput.
module fifo_mem_ctrl
    import fifo_mem_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push_valid,
    output logic                 push_ready,
    input  logic [WIDTH-1:0]     push_data,
    output logic                 pop_valid,
    input  logic                 pop_ready,
    output logic [WIDTH-1:0]     pop_data,
    output logic [$clog2(N):0]   count,
    output logic                 mem_write_en,
    output logic [$clog2(N)-1:0] mem_write_addr,
    output logic [WIDTH-1:0]     mem_data_in,
    output logic                 mem_read_en,
    output logic [$clog2(N)-1:0] mem_read_addr,
    input  logic [WIDTH-1:0]     mem_data_out
);

    localparam int PTR_W = ptr_width(N);
    localparam int CNT_W = cnt_width(N);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    ptr_t       wr_ptr;
    ptr_t       rd_ptr;
    cnt_t       mem_count;
    cnt_t       mem_count_next;
    out_state_e state_q;
    out_state_e state_d;

    logic push_fire;
    logic pop_fire;
    logic rd_issue;
    logic out_valid;

    // Handshakes depend only on registered state and flush, never on the
    // partner's valid/ready, so no combinational path crosses the FIFO.
    assign out_valid  = (state_q == OUT_VALID);
    assign push_ready = !flush && (mem_count != cnt_t'(N));
    assign pop_valid  = !flush && out_valid;
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop_valid && pop_ready;

    // Refill the output register whenever it is empty or being drained.
    assign rd_issue = !flush && (mem_count != '0) && (!out_valid || pop_fire);

    assign mem_write_en   = push_fire;
    assign mem_write_addr = wr_ptr;
    assign mem_data_in    = push_data;
    assign mem_read_en    = rd_issue;
    assign mem_read_addr  = rd_ptr;
    assign pop_data       = mem_data_out;

    assign count = mem_count + {{(CNT_W-1){1'b0}}, out_valid};

    fifo_ptr #(.N(N)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push_fire),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.N(N)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (rd_issue),
        .ptr (rd_ptr)
    );

    // Memory occupancy next value: a read issue frees its slot immediately.
    always_comb begin
        mem_count_next = mem_count;
        case ({push_fire, rd_issue})
            2'b10:   mem_count_next = mem_count + cnt_t'(1);
            2'b01:   mem_count_next = mem_count - cnt_t'(1);
            default: mem_count_next = mem_count;
        endcase
    end

    // Memory occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_count <= '0;
        end else if (flush) begin
            mem_count <= '0;
        end else begin
            mem_count <= mem_count_next;
        end
    end

    // Output-stage next state: a fresh read keeps it valid, a bare pop empties it.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = OUT_EMPTY;
        end else if (rd_issue) begin
            state_d = OUT_VALID;
        end else if (pop_fire) begin
            state_d = OUT_EMPTY;
        end
    end

    // Output-stage state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Directed and random-backpressure bench for fifo_mem_ctrl with a behavioural
// registered memory attached to its memory ports.
module tb_fifo_mem_ctrl;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int AW    = $clog2(N);
    localparam int CW    = $clog2(N) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             push_valid;
    logic             push_ready;
    logic [WIDTH-1:0] push_data;
    logic             pop_valid;
    logic             pop_ready;
    logic [WIDTH-1:0] pop_data;
    logic [CW-1:0]    count;
    logic             mem_write_en;
    logic [AW-1:0]    mem_write_addr;
    logic [WIDTH-1:0] mem_data_in;
    logic             mem_read_en;
    logic [AW-1:0]    mem_read_addr;
    logic [WIDTH-1:0] mem_data_out;

    logic [WIDTH-1:0] mem [N];

    int errors = 0;
    int checks = 0;

    fifo_mem_ctrl #(.WIDTH(WIDTH), .N(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .push_valid     (push_valid),
        .push_ready     (push_ready),
        .push_data      (push_data),
        .pop_valid      (pop_valid),
        .pop_ready      (pop_ready),
        .pop_data       (pop_data),
        .count          (count),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_data_in    (mem_data_in),
        .mem_read_en    (mem_read_en),
        .mem_read_addr  (mem_read_addr),
        .mem_data_out   (mem_data_out)
    );

    always #5 clk = ~clk;

    // External registered memory.
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_write_addr] <= mem_data_in;
        if (mem_read_en)  mem_data_out <= mem[mem_read_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] q[$];
        int sent;
        int cyc;
        logic pf;
        logic of;

        rst = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; push_data = '0;
        #12;
        chk("rst_push_ready", push_ready, 1);
        chk("rst_pop_valid",  pop_valid,  0);
        chk("rst_count",      count,      0);
        chk("rst_wr_en",      mem_write_en, 0);
        chk("rst_rd_en",      mem_read_en,  0);
        rst = 1'b0;
        tick();

        // Fill: 0xA0..0xA4 accepted, 0xA5 blocked.
        for (int i = 0; i < 6; i++) begin
            push_valid = 1'b1;
            push_data  = 32'hA0 + i;
            #1;
            chk("fill_push_ready", push_ready, (i < 5) ? 1 : 0);
            if (i < 5) tick();
        end
        chk("fill_count",     count,     5);
        chk("fill_pop_valid", pop_valid, 1);
        chk("fill_pop_data",  pop_data,  32'hA0);

        // Drain: 0xA0..0xA5 back-to-back, 0xA5 enters once a slot frees.
        pop_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("drain_pop_valid", pop_valid, 1);
            chk("drain_pop_data",  pop_data,  32'hA0 + k);
            if (k == 0) chk("drain_full_ready", push_ready, 0);
            if (k == 1) chk("drain_refill_ready", push_ready, 1);
            tick();
            if (k == 1) push_valid = 1'b0;
        end
        #1;
        chk("drain_end_pop_valid", pop_valid, 0);
        chk("drain_end_count",     count,     0);

        // Stream 0x100..0x10F with pop_ready held; pointers wrap repeatedly.
        for (int t = 0; t < 19; t++) begin
            push_valid = (t < 16);
            push_data  = 32'h100 + t;
            #1;
            chk("stream_pop_valid", pop_valid, (t >= 2 && t < 18) ? 1 : 0);
            if (t >= 2 && t < 18) chk("stream_pop_data", pop_data, 32'h100 + t - 2);
            if (t >= 2 && t < 17) chk("stream_count", count, 2);
            if (t == 17) chk("stream_tail_count", count, 1);
            if (t == 18) chk("stream_end_count", count, 0);
            tick();
        end
        push_valid = 1'b0;

        // Flush from full with both sides willing.
        pop_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_valid = 1'b1;
            push_data  = 32'hB0 + i;
            tick();
        end
        #1;
        chk("preflush_count", count, 5);
        pop_ready = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_push_ready", push_ready,   0);
        chk("flush_pop_valid",  pop_valid,    0);
        chk("flush_wr_en",      mem_write_en, 0);
        chk("flush_rd_en",      mem_read_en,  0);
        tick();
        flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        #1;
        chk("postflush_count",      count,      0);
        chk("postflush_pop_valid",  pop_valid,  0);
        chk("postflush_push_ready", push_ready, 1);

        // After flush, a fresh word must come out, not stale contents.
        push_valid = 1'b1; push_data = 32'hC0;
        tick();
        push_valid = 1'b0;
        tick();
        #1;
        chk("postflush_data_valid", pop_valid, 1);
        chk("postflush_data",       pop_data,  32'hC0);
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;

        // Asynchronous reset asserted mid-cycle with entries inside.
        push_valid = 1'b1; push_data = 32'hD0;
        tick();
        push_data = 32'hD1;
        tick();
        push_valid = 1'b0;
        #1;
        chk("prereset_count", count, 2);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_push_ready", push_ready,   1);
        chk("arst_pop_valid",  pop_valid,    0);
        chk("arst_count",      count,        0);
        chk("arst_wr_en",      mem_write_en, 0);
        chk("arst_rd_en",      mem_read_en,  0);
        #2;
        rst = 1'b0;
        tick();

        // Random backpressure against a queue scoreboard.
        sent = 0;
        cyc  = 0;
        while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
            push_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            push_data  = 32'h5000_0000 + sent;
            pop_ready  = ($urandom_range(0, 2) != 0);
            #1;
            chk("rand_count", count, q.size());
            if (count > 5) chk("rand_count_max", count, 5);
            if (q.size() < N) chk("rand_push_ready", push_ready, 1);
            pf = push_valid && push_ready;
            of = pop_valid && pop_ready;
            if (pop_valid) chk("rand_pop_nonempty", (q.size() != 0), 1);
            if (of && q.size() != 0) begin
                chk("rand_pop_data", pop_data, q[0]);
                void'(q.pop_front());
            end
            if (pf) begin
                q.push_back(push_data);
                sent++;
            end
            tick();
            cyc++;
        end
        if (cyc >= 20000) chk("rand_timeout", 1, 0);
        push_valid = 1'b0; pop_ready = 1'b0;
        #1;
        chk("rand_end_count", count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
